// File: rtl/hazard_ctrl.sv
// ID-stage hazard sequencer for the 4-stage RV32I core: load-use stalls,
// redirect flushes, data-memory freezes, operand forwarding and a stall counter.
module hazard_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      id_instr,
  input  logic             id_valid,
  input  logic             ex_redirect,
  input  logic             dmem_stall,
  output logic             if_stall,
  output logic             id_stall,
  output logic             id_flush,
  output logic             ex_bubble,
  output logic [1:0]       fwd_rs1_sel,
  output logic [1:0]       fwd_rs2_sel,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ARI_I  = 7'b0010011;
  localparam logic [6:0] OP_ARI_R  = 7'b0110011;
  localparam logic [6:0] OP_CSR    = 7'b1110011;

  typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT} state_t;

  state_t     state, state_nxt;
  logic [6:0] opc;
  logic [4:0] rd, rs1, rs2;
  logic       uses_rs1, uses_rs2, writes_rd;
  logic       lu_hazard;
  logic       unused_bits;

  logic       ex_valid, ex_wr, ex_load;
  logic [4:0] ex_rd;
  logic       wb_valid, wb_wr;
  logic [4:0] wb_rd;

  assign opc         = id_instr[6:0];
  assign rd          = id_instr[11:7];
  assign rs1         = id_instr[19:15];
  assign rs2         = id_instr[24:20];
  assign unused_bits = ^{id_instr[31:25], id_instr[13:12]};

  always_comb begin
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    case (opc)
      OP_LUI, OP_AUIPC, OP_JAL: writes_rd = 1'b1;
      OP_JALR, OP_LOAD, OP_ARI_I: begin
        uses_rs1  = 1'b1;
        writes_rd = 1'b1;
      end
      OP_BRANCH, OP_STORE: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_ARI_R: begin
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
        writes_rd = 1'b1;
      end
      OP_CSR: begin
        uses_rs1  = ~id_instr[14];
        writes_rd = 1'b1;
      end
      default: ;
    endcase
  end

  // Masking in LU_STALL changes nothing functionally (EX holds the bubble
  // then) but pins the stall to exactly one cycle.
  always_comb begin
    lu_hazard = ex_valid & ex_load & ex_wr & (ex_rd != 5'd0) & id_valid &
                ((uses_rs1 & (rs1 == ex_rd)) | (uses_rs2 & (rs2 == ex_rd))) &
                (state != LU_STALL);
  end

  function automatic logic [1:0] fwd_sel(input logic used, input logic [4:0] rs,
                                         input logic exv, input logic exw,
                                         input logic exl, input logic [4:0] exr,
                                         input logic wbv, input logic wbw,
                                         input logic [4:0] wbr);
    if (!used || rs == 5'd0)             return 2'd0;
    if (exv && exw && !exl && exr == rs) return 2'd1;
    if (wbv && wbw && wbr == rs)         return 2'd2;
    return 2'd0;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = RUN;
    if (dmem_stall)       state_nxt = MEM_WAIT;
    else if (ex_redirect) state_nxt = RUN;
    else if (lu_hazard)   state_nxt = LU_STALL;
  end

  always_comb begin
    if_stall    = 1'b0;
    id_stall    = 1'b0;
    id_flush    = 1'b0;
    ex_bubble   = 1'b0;
    fwd_rs1_sel = fwd_sel(uses_rs1, rs1, ex_valid, ex_wr, ex_load, ex_rd, wb_valid, wb_wr, wb_rd);
    fwd_rs2_sel = fwd_sel(uses_rs2, rs2, ex_valid, ex_wr, ex_load, ex_rd, wb_valid, wb_wr, wb_rd);
    if (rst) begin
      id_flush    = 1'b1;
      ex_bubble   = 1'b1;
      fwd_rs1_sel = '0;
      fwd_rs2_sel = '0;
    end else if (dmem_stall) begin
      if_stall = 1'b1;
      id_stall = 1'b1;
    end else if (ex_redirect) begin
      id_flush  = 1'b1;
      ex_bubble = 1'b1;
    end else if (lu_hazard) begin
      if_stall  = 1'b1;
      id_stall  = 1'b1;
      ex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid <= 1'b0;
      ex_wr    <= 1'b0;
      ex_load  <= 1'b0;
      ex_rd    <= '0;
      wb_valid <= 1'b0;
      wb_wr    <= 1'b0;
      wb_rd    <= '0;
    end else if (!dmem_stall) begin
      wb_valid <= ex_valid;
      wb_wr    <= ex_wr;
      wb_rd    <= ex_rd;
      ex_valid <= id_valid & ~ex_bubble;
      ex_wr    <= writes_rd;
      ex_load  <= (opc == OP_LOAD);
      ex_rd    <= rd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      stall_cycles <= '0;
    else if (if_stall && !(&stall_cycles))
      stall_cycles <= stall_cycles + CNT_W'(1);
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized bench for hazard_ctrl against a pipeline reference model that
// keeps whole instruction words in EX/WB and decodes them on demand.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst, id_valid, ex_redirect, dmem_stall;
  logic [31:0] id_instr;
  logic        if_stall, id_stall, id_flush, ex_bubble;
  logic [1:0]  fwd_rs1_sel, fwd_rs2_sel;
  logic [31:0] stall_cycles;
  logic        s_if_stall, s_id_stall, s_id_flush, s_ex_bubble;
  logic [1:0]  s_fwd1, s_fwd2;
  logic [1:0]  s_cnt;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  hazard_ctrl u_dut (
    .clk(clk), .rst(rst), .id_instr(id_instr), .id_valid(id_valid),
    .ex_redirect(ex_redirect), .dmem_stall(dmem_stall),
    .if_stall(if_stall), .id_stall(id_stall), .id_flush(id_flush),
    .ex_bubble(ex_bubble), .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel),
    .stall_cycles(stall_cycles)
  );

  hazard_ctrl #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .id_instr(id_instr), .id_valid(id_valid),
    .ex_redirect(ex_redirect), .dmem_stall(dmem_stall),
    .if_stall(s_if_stall), .id_stall(s_id_stall), .id_flush(s_id_flush),
    .ex_bubble(s_ex_bubble), .fwd_rs1_sel(s_fwd1), .fwd_rs2_sel(s_fwd2),
    .stall_cycles(s_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: raw instruction words in flight plus counters.
  logic [31:0] m_ex_i, m_wb_i;
  bit          m_ex_v, m_wb_v;
  longint unsigned m_cnt;
  int unsigned     m_sat;

  function automatic bit is_op(input logic [31:0] i, input logic [6:0] o);
    return i[6:0] == o;
  endfunction

  function automatic bit m_uses1(input logic [31:0] i);
    return is_op(i, 7'h67) || is_op(i, 7'h63) || is_op(i, 7'h03) || is_op(i, 7'h23) ||
           is_op(i, 7'h13) || is_op(i, 7'h33) || (is_op(i, 7'h73) && !i[14]);
  endfunction

  function automatic bit m_uses2(input logic [31:0] i);
    return is_op(i, 7'h63) || is_op(i, 7'h23) || is_op(i, 7'h33);
  endfunction

  function automatic bit m_writes(input logic [31:0] i);
    return is_op(i, 7'h37) || is_op(i, 7'h17) || is_op(i, 7'h6F) || is_op(i, 7'h67) ||
           is_op(i, 7'h03) || is_op(i, 7'h13) || is_op(i, 7'h33) || is_op(i, 7'h73);
  endfunction

  function automatic logic [1:0] m_fwd(input bit used, input logic [4:0] rs);
    if (!used || rs == 0) return 2'd0;
    if (m_ex_v && m_writes(m_ex_i) && !is_op(m_ex_i, 7'h03) && m_ex_i[11:7] == rs) return 2'd1;
    if (m_wb_v && m_writes(m_wb_i) && m_wb_i[11:7] == rs) return 2'd2;
    return 2'd0;
  endfunction

  task automatic step(input bit r, input logic [31:0] instr, input bit v,
                      input bit redir, input bit dm);
    bit e_if, e_id, e_fl, e_bb, lu;
    logic [1:0] e_f1, e_f2;
    logic [4:0] erd;
    @(negedge clk);
    rst = r; id_instr = instr; id_valid = v; ex_redirect = redir; dmem_stall = dm;
    #1;
    erd  = m_ex_i[11:7];
    lu   = m_ex_v && is_op(m_ex_i, 7'h03) && m_writes(m_ex_i) && erd != 0 && v &&
           ((m_uses1(instr) && instr[19:15] == erd) || (m_uses2(instr) && instr[24:20] == erd));
    e_f1 = m_fwd(m_uses1(instr), instr[19:15]);
    e_f2 = m_fwd(m_uses2(instr), instr[24:20]);
    {e_if, e_id, e_fl, e_bb} = 4'b0000;
    if (r) begin
      {e_if, e_id, e_fl, e_bb} = 4'b0011; e_f1 = 0; e_f2 = 0;
    end else if (dm)    {e_if, e_id, e_fl, e_bb} = 4'b1100;
    else if (redir)     {e_if, e_id, e_fl, e_bb} = 4'b0011;
    else if (lu)        {e_if, e_id, e_fl, e_bb} = 4'b1101;
    check("if_stall",  32'(if_stall),  32'(e_if));
    check("id_stall",  32'(id_stall),  32'(e_id));
    check("id_flush",  32'(id_flush),  32'(e_fl));
    check("ex_bubble", 32'(ex_bubble), 32'(e_bb));
    check("fwd_rs1",   32'(fwd_rs1_sel), 32'(e_f1));
    check("fwd_rs2",   32'(fwd_rs2_sel), 32'(e_f2));
    check("stall_cnt", stall_cycles, 32'(m_cnt));
    check("sat_cnt",   32'(s_cnt), m_sat);
    check("sat_if_stall", 32'(s_if_stall), 32'(e_if));
    if (r) begin
      m_ex_v = 0; m_wb_v = 0; m_cnt = 0; m_sat = 0;
    end else begin
      if (e_if) begin
        if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
        if (m_sat < 3) m_sat++;
      end
      if (!dm) begin
        m_wb_v = m_ex_v; m_wb_i = m_ex_i;
        m_ex_v = v && !e_bb; m_ex_i = instr;
      end
    end
  endtask

  task automatic do_reset();
    step(1, 32'h0, 0, 0, 0);
    step(1, 32'h0, 0, 0, 0);
  endtask

  localparam logic [31:0] LW   = 32'h0000A283;  // lw   x5,0(x1)
  localparam logic [31:0] ADD  = 32'h00728333;  // add  x6,x5,x7
  localparam logic [31:0] ADDI = 32'h00100293;  // addi x5,x0,1
  localparam logic [31:0] NOPI = 32'h00000493;  // addi x9,x0,0
  localparam logic [31:0] ADI0 = 32'h00100013;  // addi x0,x0,1
  localparam logic [31:0] ADD0 = 32'h00000333;  // add  x6,x0,x0

  logic [6:0] ops [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                           7'h23, 7'h13, 7'h33, 7'h73, 7'h7F};

  initial begin
    logic [31:0] ri;
    m_ex_i = 0; m_wb_i = 0; m_ex_v = 0; m_wb_v = 0; m_cnt = 0; m_sat = 0;
    rst = 1; id_instr = 0; id_valid = 0; ex_redirect = 0; dmem_stall = 0;

    // load-use then WB forwarding
    do_reset();
    check("rst_flush", 32'(id_flush), 32'd1);
    step(0, LW, 1, 0, 0);
    step(0, ADD, 1, 0, 0);
    check("lu_stall", 32'({if_stall, id_stall, ex_bubble}), 32'h7);
    step(0, ADD, 1, 0, 0);
    check("lu_fwd1", 32'(fwd_rs1_sel), 32'd2);
    check("lu_cnt", stall_cycles, 32'd1);

    // EX and WB forwarding from an ALU result
    do_reset();
    step(0, ADDI, 1, 0, 0);
    step(0, ADD, 1, 0, 0);
    check("ex_fwd1", 32'(fwd_rs1_sel), 32'd1);
    step(0, ADDI, 1, 0, 0);
    step(0, NOPI, 1, 0, 0);
    step(0, ADD, 1, 0, 0);
    check("wb_fwd1", 32'(fwd_rs1_sel), 32'd2);

    // x0 never forwards
    step(0, ADI0, 1, 0, 0);
    step(0, ADD0, 1, 0, 0);
    check("x0_fwd", 32'({fwd_rs1_sel, fwd_rs2_sel, if_stall}), 32'd0);

    // redirect overrides load-use
    do_reset();
    step(0, LW, 1, 0, 0);
    step(0, ADD, 1, 1, 0);
    check("redir_ctl", 32'({if_stall, id_flush, ex_bubble}), 32'h3);
    step(0, ADD, 1, 0, 0);
    check("redir_cnt", stall_cycles, 32'd0);

    // memory wait during the load-use stall
    do_reset();
    step(0, LW, 1, 0, 0);
    step(0, ADD, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, ADD, 1, 0, 1);
    step(0, ADD, 1, 0, 0);
    check("mw_fwd1", 32'(fwd_rs1_sel), 32'd2);
    check("mw_cnt", stall_cycles, 32'd4);

    // reset during MEM_WAIT
    step(0, ADDI, 1, 0, 0);
    step(0, NOPI, 1, 0, 1);
    step(1, NOPI, 1, 0, 1);
    step(0, ADD, 1, 0, 0);
    check("rst_mw_fwd", 32'(fwd_rs1_sel), 32'd0);
    check("rst_mw_cnt", stall_cycles, 32'd0);

    // 2-bit counter saturation
    for (int i = 0; i < 5; i++) step(0, NOPI, 1, 0, 1);
    step(0, NOPI, 1, 0, 0);
    check("sat_hold", 32'(s_cnt), 32'd3);
    check("sat_main", stall_cycles, 32'd5);

    // randomized traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      ri = $urandom;
      ri[6:0]   = ops[$urandom_range(0, 10)];
      ri[11:7]  = 5'($urandom_range(0, 7));
      ri[19:15] = 5'($urandom_range(0, 7));
      ri[24:20] = 5'($urandom_range(0, 7));
      step($urandom_range(0, 99) < 2, ri, $urandom_range(0, 9) != 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencer for the ID stage of the 4-stage RV32I core (IF, ID, EX, WB).
- Inspects the instruction in ID, tracks the destination registers of the instructions in EX and WB, and produces stall, flush, bubble and operand-forwarding controls.
- Resolves load-use hazards, taken-branch/jump redirects and data-memory wait states.
- Keeps a saturating stall-cycle counter for performance debug.

Parameters:
CNT_W, 32, width of the stall_cycles performance counter (saturates at all-ones).

Ports:
clk  input  1  core clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
id_instr  input  32  raw instruction held in the IF/ID register
id_valid  input  1  id_instr is a real instruction (0 = bubble)
ex_redirect  input  1  branch taken or JAL/JALR resolved in EX this cycle
dmem_stall  input  1  data memory not ready; whole pipeline must freeze
if_stall  output  1  hold PC
id_stall  output  1  hold the IF/ID register
id_flush  output  1  load a bubble into the IF/ID register
ex_bubble  output  1  load a NOP into the ID/EX register instead of the ID instruction
fwd_rs1_sel  output  2  0 = regfile, 1 = EX result, 2 = WB result
fwd_rs2_sel  output  2  same encoding as fwd_rs1_sel
stall_cycles  output  CNT_W  count of cycles with if_stall=1

Behaviour:
- Field decode from id_instr, standard RV32I positions: opcode[6:0], rd[11:7], funct3[14:12], rs1[19:15], rs2[24:20].
- uses_rs1: JALR, BRANCH, LOAD, STORE, ARI_ITYPE, ARI_RTYPE, and CSR with funct3[2]=0.
- uses_rs2: BRANCH, STORE, ARI_RTYPE.
- writes_rd: LUI, AUIPC, JAL, JALR, LOAD, ARI_ITYPE, ARI_RTYPE, CSR.
- A register match against x0 is never a hazard and never forwards.
- Tracking slots (registered):
  - EX slot: {valid, rd, writes_rd, is_load}.
  - WB slot: {valid, rd, writes_rd}.
  - Normal advance: WB <= EX; EX <= ID fields, with valid = id_valid & ~ex_bubble.
- FSM states: RUN, LU_STALL, MEM_WAIT. Reset state is RUN.
- Priority, evaluated each cycle:
  1. dmem_stall=1:
     - Outputs: if_stall=1, id_stall=1, id_flush=0, ex_bubble=0.
     - Both slots hold; next state MEM_WAIT.
     - A pending ex_redirect is ignored this cycle and honoured when dmem_stall drops, because EX is held.
  2. ex_redirect=1:
     - Outputs: if_stall=0, id_stall=0, id_flush=1, ex_bubble=1.
     - EX slot loads invalid; next state RUN.
     - A simultaneous load-use hazard is discarded.
  3. Load-use hazard:
     - Condition: EX.valid & EX.is_load & EX.writes_rd & EX.rd!=0 & id_valid & ((uses_rs1 & rs1==EX.rd) | (uses_rs2 & rs2==EX.rd)).
     - Outputs: if_stall=1, id_stall=1, ex_bubble=1, id_flush=0.
     - Next state LU_STALL.
  4. Otherwise: all four controls 0; next state RUN.
- LU_STALL lasts exactly one cycle. The load is then in WB, and the dependent instruction issues with WB forwarding. Priorities 1 and 2 still apply while in LU_STALL.
- MEM_WAIT exits to RUN on the first cycle dmem_stall=0; the priority list is evaluated normally in that cycle.
- Forwarding (combinational, rs1 and rs2 handled independently):
  - Select 1 when EX.valid & EX.writes_rd & ~EX.is_load & EX.rd==rs & rs!=0.
  - Else select 2 when WB.valid & WB.writes_rd & WB.rd==rs & rs!=0.
  - Else select 0. EX takes priority over WB.
  - Select is 0 for an operand the instruction does not use.
- stall_cycles:
  - Increments by 1 on every cycle with if_stall=1 while rst=0.
  - Holds at 2^CNT_W-1.
  - Cleared only by rst.
- Reset (rst=1, including mid-stall or mid-MEM_WAIT):
  - Both slots invalid, state RUN, stall_cycles=0.
  - Outputs during and after reset, until new input arrives: if_stall=0, id_stall=0, id_flush=1, ex_bubble=1, fwd selects 0.
- Latency: all control outputs are combinational from current inputs and slot state. Slot and FSM updates take effect on the next edge.

Test Plan:
- lw x5,0(x1) (0x0000A283), then add x6,x5,x7 (0x00728333):
  - Cycle 1: if_stall=id_stall=ex_bubble=1, state LU_STALL.
  - Cycle 2: no stall, fwd_rs1_sel=2, fwd_rs2_sel=0, stall_cycles=1.
- addi x5,x0,1 (0x00100293), then add x6,x5,x7 -> no stall, fwd_rs1_sel=1. One extra instruction between them -> fwd_rs1_sel=2.
- addi x0,x0,1, then add x6,x0,x0 -> fwd selects 0 and no stall.
- Load-use condition with ex_redirect=1 in the same cycle -> id_flush=1, ex_bubble=1, if_stall=0; next state RUN; stall_cycles unchanged.
- dmem_stall high for 3 cycles during LU_STALL:
  - if_stall=1 and slots frozen for 3 cycles.
  - Then RUN with WB forwarding; stall_cycles increments by 4 in total.
- rst asserted during MEM_WAIT -> next cycle state RUN, slots invalid, stall_cycles=0, fwd selects 0. CNT_W=2 with 5 stall cycles -> stall_cycles=3 and holds.
